maclaurin_series_unit: RTL and testbench
========================================

Name: maclaurin_series_unit

Overview:
- Parametrised iterative fixed-point Maclaurin evaluator. It generalises the single-function exp engine to three selectable functions (exp, sin, cos), a configurable fraction width and a configurable term count.
- Accepts an unsigned fraction x in [0,1) on a start pulse and accumulates TERMS series terms, using one shared multiplier and a reciprocal constant table.
- Returns an unsigned Q(INT).(FRAC) result with a one-cycle done pulse.
- Sits beside or replaces the exp top in the series-calculator datapath.

Parameters:
- FRAC, 16: fraction bits. xBus is Q0.FRAC.
- INT, 2: integer bits of the result. rBus is Q(INT).(FRAC).
- TERMS, 8: series terms summed, including the constant or x term. Legal range 2..12.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin computation. Sampled only in IDLE.
- mode  in  2  function select: 00 exp, 01 sin, 10 cos, 11 reserved. Latched with start.
- xBus  in  FRAC  operand x, unsigned Q0.FRAC. Latched with start.
- rBus  out  INT+FRAC  result, registered, held until the next done.
- done  out  1  one-cycle pulse when rBus is valid.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- err  out  1  high with done when mode=11. rBus=0 in that case.

Behaviour:
- Reset: state=IDLE; rBus=0, done=0, busy=0, err=0; internal acc, term and k cleared. Reset takes effect mid-computation; the operation in flight is discarded with no done.
- Internal widths: acc and term are INT+FRAC bits unsigned. Each multiply forms a full 2*(INT+FRAC)-bit product, shifts right by FRAC and truncates (no rounding).
- Reciprocal table: recip(n) = floor(2^FRAC/n), a constant computed at elaboration for every divisor used.
- Divisor d(k):
  - exp: d=k
  - sin: d=(2k)(2k+1)
  - cos: d=(2k-1)(2k)
- IDLE, start=1:
  - Latch x and mode.
  - term=acc = 1.0 (1<<FRAC) for exp/cos, or x for sin.
  - k=1. Go to MULX.
  - mode=11 goes straight to DONE with err=1.
- MULX: term=(term*x)>>FRAC. Next state is MULX2 for sin/cos, MULR for exp.
- MULX2: term=(term*x)>>FRAC. Go to MULR.
- MULR: term=(term*recip(d(k)))>>FRAC. Go to ACC.
- ACC:
  - exp: acc=acc+term.
  - sin/cos: acc=acc-term when k is odd, acc+term when k is even.
  - k=k+1.
  - If k==TERMS-1 (before increment), go to DONE; else go to MULX.
- DONE: rBus=acc, done=1, busy=1 for exactly this cycle. Go to IDLE.
- Latency, from the start-sampling edge to the done-high cycle:
  - exp: 3*(TERMS-1)+1 cycles (22 at default).
  - sin/cos: 4*(TERMS-1)+1 cycles (29 at default).
  - mode=11: 2 cycles.
- No overflow or underflow is possible for x<1: sin/cos partial sums stay in [0,1] and exp stays below e<4. No saturation logic is required.
- start while busy, or in the DONE cycle, is ignored. No queueing.
- start held high: a new operation is accepted in the first IDLE cycle after DONE.
- xBus and mode changes after the start cycle have no effect on the operation in flight.
- Terms that truncate to 0 still take their full cycles. Latency is data-independent.

Test Plan:
- Reset, then x=0x4000, mode=00, one start pulse -> done exactly 22 cycles later; rBus within 8 LSB below 0x148B5 (e^0.25); err=0; busy high 22 cycles.
- x=0x0000 for each mode -> exp rBus=0x10000 exactly; sin rBus=0x00000; cos rBus=0x10000.
- x=0x8000, mode=01 then mode=10 back-to-back, with start re-asserted the cycle after done -> sin rBus within 8 LSB of 0x07ABC; cos within 8 LSB of 0x0E0A9; each done 29 cycles after its start.
- x=0xFFFF, mode=00 -> rBus in [0x2B7D0,0x2B7E2]; no wrap (bits 17:16 = 2'b10).
- start re-pulsed at cycle 5 of a busy exp op, with xBus and mode changed at the same time -> ignored; a single done with the original operand's result. Then mode=11 -> done and err high 2 cycles after start; rBus=0.
- rst asserted at cycle 10 of a sin op -> next cycle busy=0, done=0, rBus=0. A following start with x=0x4000, mode=00 completes normally in 22 cycles.

Source files
------------

// File: rtl/maclaurin_series_unit.sv
// Iterative fixed-point Maclaurin evaluator for exp, sin and cos.
// One shared multiplier walks x-powers and reciprocal factorial terms.
module maclaurin_series_unit #(
  parameter int FRAC  = 16,
  parameter int INT   = 2,
  parameter int TERMS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [FRAC-1:0]     xBus,
  output logic [INT+FRAC-1:0] rBus,
  output logic                done,
  output logic                busy,
  output logic                err
);

  localparam int W  = INT + FRAC;
  localparam int KW = $clog2(TERMS + 1);
  localparam int NR = 2 ** KW;

  localparam logic [W-1:0] ONE =
    W'(64'd1 << FRAC);
  localparam logic [KW-1:0] KLAST =
    KW'(TERMS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULX,
    S_MULX2,
    S_MULR,
    S_ACC,
    S_RSV,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [FRAC-1:0] x_q, x_d;
  logic [1:0]      mode_q, mode_d;
  logic [W-1:0]    term_q, term_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    r_q, r_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic            trig;
  logic            sub;
  logic [W-1:0]    recip;
  logic [W-1:0]    mul_b;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    prod_sh;

  // Reciprocal tables indexed by k; entry 0 is never selected.
  logic [W-1:0] r_exp [NR];
  logic [W-1:0] r_sin [NR];
  logic [W-1:0] r_cos [NR];

  for (genvar g = 0; g < NR; g++) begin : g_rcp
    localparam int DE = (g < 1) ? 1 : g;
    localparam int DS = (g < 1) ? 1 : (2*g) * (2*g + 1);
    localparam int DC = (g < 1) ? 1 : (2*g - 1) * (2*g);
    assign r_exp[g] = W'((64'd1 << FRAC) / DE);
    assign r_sin[g] = W'((64'd1 << FRAC) / DS);
    assign r_cos[g] = W'((64'd1 << FRAC) / DC);
  end

  assign trig = mode_q[0] ^ mode_q[1];
  assign sub  = trig & k_q[0];

  always_comb begin
    recip = r_exp[k_q];
    unique case (1'b1)
      (mode_q == 2'b01): recip = r_sin[k_q];
      (mode_q == 2'b10): recip = r_cos[k_q];
      default:           recip = r_exp[k_q];
    endcase
  end

  assign mul_b = (state_q == S_MULR) ?
                 recip : {{INT{1'b0}}, x_q};
  assign prod  = {{W{1'b0}}, term_q} *
                 {{W{1'b0}}, mul_b};
  assign prod_sh = W'(prod >> FRAC);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start)
          state_d = (mode == 2'b11) ? S_RSV : S_MULX;
      end
      S_MULX:  state_d = trig ? S_MULX2 : S_MULR;
      S_MULX2: state_d = S_MULR;
      S_MULR:  state_d = S_ACC;
      S_ACC:   state_d = (k_q == KLAST) ? S_DONE : S_MULX;
      S_RSV:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    mode_d = mode_q;
    term_d = term_q;
    acc_d  = acc_q;
    k_d    = k_q;
    r_d    = r_q;
    err_d  = 1'b0;
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d    = xBus;
          mode_d = mode;
          term_d = (mode == 2'b01) ? {{INT{1'b0}}, xBus} : ONE;
          acc_d  = (mode == 2'b01) ? {{INT{1'b0}}, xBus} : ONE;
          k_d    = KW'(1);
        end
      end
      S_MULX, S_MULX2, S_MULR: term_d = prod_sh;
      S_ACC: begin
        acc_d = sub ? (acc_q - term_q) : (acc_q + term_q);
        k_d   = k_q + KW'(1);
        if (k_q == KLAST) r_d = acc_d;
      end
      S_RSV: begin
        r_d   = '0;
        err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      mode_q <= '0;
      term_q <= '0;
      acc_q  <= '0;
      k_q    <= '0;
      r_q    <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      mode_q <= mode_d;
      term_q <= term_d;
      acc_q  <= acc_d;
      k_q    <= k_d;
      r_q    <= r_d;
      done_q <= done_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign rBus = r_q;
  assign done = done_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: tb/tb_maclaurin_series_unit.sv
// Randomised and directed bench for maclaurin_series_unit.
// Results are compared against a plain-arithmetic series model.
module tb_maclaurin_series_unit;

  localparam int FRAC  = 16;
  localparam int INT   = 2;
  localparam int TERMS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] xBus;
  logic [17:0] rBus;
  logic        done;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  maclaurin_series_unit #(
    .FRAC(FRAC), .INT(INT), .TERMS(TERMS)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mode(mode), .xBus(xBus), .rBus(rBus),
    .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] model(
    input logic [15:0] x, input logic [1:0] m);
    longint acc, term, d;
    if (m == 2'b11) return 18'd0;
    acc  = (m == 2'b01) ? longint'(x) : 65536;
    term = acc;
    for (int k = 1; k < TERMS; k++) begin
      if (m == 2'b00)      d = k;
      else if (m == 2'b01) d = (2*k) * (2*k + 1);
      else                 d = (2*k - 1) * (2*k);
      term = (term * x) >> 16;
      if (m != 2'b00) term = (term * x) >> 16;
      term = (term * (65536 / d)) >> 16;
      if (m == 2'b00 || (k % 2) == 0) acc = acc + term;
      else                            acc = acc - term;
    end
    return acc[17:0];
  endfunction

  task automatic run_op(input logic [15:0] x,
                        input logic [1:0] m,
                        input int rep_at,
                        output int lat,
                        output logic [17:0] r,
                        output logic e,
                        output int bc);
    @(negedge clk);
    xBus = x; mode = m; start = 1'b1;
    lat = -1; r = '0; e = 1'b0; bc = 0;
    @(posedge clk);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == rep_at) begin
        start = 1'b1; xBus = ~x; mode = 2'b01;
      end
      if (n == rep_at + 1) start = 1'b0;
      if (busy) bc++;
      if (done) begin
        lat = n; r = rBus; e = err;
        break;
      end
    end
  endtask

  task automatic do_op(input string tag,
                       input logic [15:0] x,
                       input logic [1:0] m,
                       input int rep_at,
                       output logic [17:0] r);
    int lat, bc, want;
    logic e;
    run_op(x, m, rep_at, lat, r, e, bc);
    if (m == 2'b00)      want = 3*(TERMS-1) + 1;
    else if (m == 2'b11) want = 2;
    else                 want = 4*(TERMS-1) + 1;
    chk({tag, "_lat"}, lat, want);
    chk({tag, "_r"}, r, model(x, m));
    chk({tag, "_err"}, e, (m == 2'b11));
    chk({tag, "_busy"}, bc, want);
  endtask

  function automatic bit near(input int a,
                              input int b, input int tol);
    return (a >= b - tol) && (a <= b + tol);
  endfunction

  initial begin
    logic [17:0] r;
    logic [15:0] rx;
    logic [1:0]  rm;
    int extra;

    rst = 1'b1; start = 1'b0; mode = '0; xBus = '0;
    repeat (3) @(negedge clk);
    chk("rst_rbus", rBus, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    do_op("exp025", 16'h4000, 2'b00, 0, r);
    chk("exp025_win",
        (r <= 18'h148B5) && (r >= 18'h148B5 - 8), 1);

    do_op("exp0", 16'h0000, 2'b00, 0, r);
    chk("exp0_val", r, 18'h10000);
    do_op("sin0", 16'h0000, 2'b01, 0, r);
    chk("sin0_val", r, 18'h00000);
    do_op("cos0", 16'h0000, 2'b10, 0, r);
    chk("cos0_val", r, 18'h10000);

    do_op("sin05", 16'h8000, 2'b01, 0, r);
    chk("sin05_win", near(int'(r), 'h7ABC, 8), 1);
    do_op("cos05", 16'h8000, 2'b10, 0, r);
    chk("cos05_win", near(int'(r), 'hE0A9, 8), 1);

    do_op("expmax", 16'hFFFF, 2'b00, 0, r);
    chk("expmax_win",
        (r >= 18'h2B7D0) && (r <= 18'h2B7E2), 1);
    chk("expmax_top", r[17:16], 2'b10);

    do_op("ignore", 16'h4000, 2'b00, 5, r);
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("ignore_single", extra, 0);

    do_op("rsv", 16'h1234, 2'b11, 0, r);

    @(negedge clk);
    xBus = 16'h8000; mode = 2'b01; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rbus", rBus, 0);
    rst = 1'b0;
    do_op("postrst", 16'h4000, 2'b00, 0, r);

    for (int i = 0; i < 10; i++) begin
      rx = 16'($urandom_range(0, 65535));
      rm = 2'($urandom_range(0, 2));
      do_op($sformatf("rnd%0d", i), rx, rm, 0, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
